// File: rtl/uart_cmd_ctrl_pkg.sv
// ============================================================================
//  Module      : uart_cmd_ctrl_pkg
//  Description : Shared frame-controller definitions: FSM state encoding,
//                divisor register addresses, default sync marker and the
//                frame checksum helper (also used by the host-side encoder).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_cmd_ctrl_pkg;

  // Frame assembly states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_CHK  = 2'd3
  } cmd_state_t;

  localparam logic [7:0] c_ADDR_BAUD_LO      = 8'h00;
  localparam logic [7:0] c_ADDR_BAUD_HI      = 8'h01;
  localparam logic [7:0] c_SYNC_BYTE_DEFAULT = 8'hA5;

  // Checksum byte carried in the last position of a frame
  function automatic logic [7:0] frame_chk(input logic [7:0] addr, input logic [7:0] data);
    return addr ^ data;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_cmd_ctrl_if.sv
// ============================================================================
//  Module      : uart_cmd_ctrl_if
//  Description : Byte stream from uart_rx plus the register write bus.
//                slave  = the frame controller (consumes bytes, issues writes)
//                master = the environment (supplies bytes, observes writes)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_cmd_ctrl_if;
  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;

  modport slave (
    input  rx_done_tick,
    input  rx_data,
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport master (
    output rx_done_tick,
    output rx_data,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );
endinterface

`default_nettype wire

// File: rtl/uart_cmd_timeout.sv
// ============================================================================
//  Module      : uart_cmd_timeout
//  Description : Inter-byte watchdog. Counts enabled cycles since the last
//                clear; expire is asserted while the count sits at
//                TIMEOUT_CYC-1 and enable is high.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_cmd_timeout #(
  parameter int unsigned TIMEOUT_CYC = 32'd200000
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic clear,
  input  wire logic enable,
  output logic      expire
);

  localparam int unsigned c_CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TIMEOUT_CYC - 1);

  logic [c_CNT_W-1:0] r_cnt;
  logic               w_at_last;

  assign w_at_last = (r_cnt == c_LAST);
  assign expire    = enable && w_at_last;

  // Cycle counter: restarts on clear, parks at the last value until cleared
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable && !w_at_last) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_cmd_ctrl.sv
// ============================================================================
//  Module      : uart_cmd_ctrl
//  Description : Assembles SYNC,ADDR,DATA,CHK frames from uart_rx and issues
//                one register write per valid frame. Addresses 0x00/0x01 land
//                in the local baud divisor; others go out on the write bus.
//                Optional statistics counters: define UART_CMD_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_cmd_ctrl
  import uart_cmd_ctrl_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE   = c_SYNC_BYTE_DEFAULT,
  parameter logic [15:0] DEFAULT_DIV = 16'd163,
  parameter int unsigned TIMEOUT_CYC = 32'd200000
) (
  input  wire logic      clk,
  input  wire logic      reset,
  uart_cmd_ctrl_if.slave bus,
  output logic [15:0]    baud_div,
  output logic           busy,
  output logic           frame_err,
  output logic [15:0]    frame_cnt,
  output logic [15:0]    err_cnt
);

  cmd_state_t  r_state, w_state_next;
  logic [7:0]  r_addr, r_data;
  logic        r_wr_en;
  logic [7:0]  r_wr_addr, r_wr_data;
  logic [15:0] r_baud_div;
  logic        r_frame_err;

  logic        w_latch_addr, w_latch_data;
  logic        w_chk_ok, w_chk_bad, w_timed_out;
  logic        w_expire, w_to_clear, w_to_enable;
  logic        w_is_div, w_div_zero;
  logic [15:0] w_div_cand;
  logic        w_reg_wr, w_div_wr, w_err;

  assign w_to_clear  = bus.rx_done_tick || (r_state == ST_IDLE);
  assign w_to_enable = (r_state != ST_IDLE);

  uart_cmd_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (w_to_clear),
    .enable (w_to_enable),
    .expire (w_expire)
  );

  // Frame state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Next state; a byte arriving on the expiry cycle takes priority over the timeout
  always_comb begin
    w_state_next = r_state;
    w_latch_addr = 1'b0;
    w_latch_data = 1'b0;
    w_chk_ok     = 1'b0;
    w_chk_bad    = 1'b0;
    w_timed_out  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.rx_done_tick && (bus.rx_data == SYNC_BYTE)) w_state_next = ST_ADDR;
      end
      ST_ADDR: begin
        if (bus.rx_done_tick) begin
          w_latch_addr = 1'b1;
          w_state_next = ST_DATA;
        end else if (w_expire) begin
          w_timed_out  = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (bus.rx_done_tick) begin
          w_latch_data = 1'b1;
          w_state_next = ST_CHK;
        end else if (w_expire) begin
          w_timed_out  = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      ST_CHK: begin
        if (bus.rx_done_tick) begin
          w_state_next = ST_IDLE;
          if (bus.rx_data == frame_chk(r_addr, r_data)) w_chk_ok  = 1'b1;
          else                                          w_chk_bad = 1'b1;
        end else if (w_expire) begin
          w_timed_out  = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Divisor candidate for a commit that targets one of the baud bytes
  always_comb begin
    w_is_div   = 1'b0;
    w_div_cand = r_baud_div;
    if (r_addr == c_ADDR_BAUD_LO) begin
      w_is_div   = 1'b1;
      w_div_cand = {r_baud_div[15:8], r_data};
    end else if (r_addr == c_ADDR_BAUD_HI) begin
      w_is_div   = 1'b1;
      w_div_cand = {r_data, r_baud_div[7:0]};
    end
  end

  // A zero divisor would stall the sample-rate counter, so it is refused
  assign w_div_zero = (w_div_cand == 16'd0);
  assign w_reg_wr   = w_chk_ok && !w_is_div;
  assign w_div_wr   = w_chk_ok && w_is_div && !w_div_zero;
  assign w_err      = w_chk_bad || w_timed_out || (w_chk_ok && w_is_div && w_div_zero);

  // Address/data capture while the frame is being assembled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr <= 8'd0;
      r_data <= 8'd0;
    end else begin
      if (w_latch_addr) r_addr <= bus.rx_data;
      if (w_latch_data) r_data <= bus.rx_data;
    end
  end

  // Registered commit: write strobe, divisor update and error pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_en     <= 1'b0;
      r_wr_addr   <= 8'd0;
      r_wr_data   <= 8'd0;
      r_baud_div  <= DEFAULT_DIV;
      r_frame_err <= 1'b0;
    end else begin
      r_wr_en     <= w_reg_wr;
      r_frame_err <= w_err;
      if (w_reg_wr) begin
        r_wr_addr <= r_addr;
        r_wr_data <= r_data;
      end
      if (w_div_wr) r_baud_div <= w_div_cand;
    end
  end

  assign bus.wr_en   = r_wr_en;
  assign bus.wr_addr = r_wr_addr;
  assign bus.wr_data = r_wr_data;
  assign baud_div    = r_baud_div;
  assign frame_err   = r_frame_err;
  assign busy        = (r_state != ST_IDLE);

`ifdef UART_CMD_STATS_EN
  logic        w_good;
  logic [15:0] r_frame_cnt, r_err_cnt;

  assign w_good = w_reg_wr || w_div_wr;

  // Saturating good-frame and error counters, cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_frame_cnt <= 16'd0;
      r_err_cnt   <= 16'd0;
    end else begin
      if (w_good && (r_frame_cnt != 16'hFFFF)) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_err  && (r_err_cnt   != 16'hFFFF)) r_err_cnt   <= r_err_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
  assign err_cnt   = r_err_cnt;
`else
  assign frame_cnt = 16'd0;
  assign err_cnt   = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
// ============================================================================
//  Module      : tb_uart_cmd_ctrl
//  Description : Scoreboard bench for uart_cmd_ctrl. Stimulus pushes expected
//                write / error / divisor-change events; a monitor pops and
//                compares them as the DUT produces them.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_cmd_ctrl;

  localparam int          T       = 64;
  localparam logic [15:0] DEF_DIV = 16'd163;
  localparam logic [7:0]  SYNC    = 8'hA5;
  localparam int K_WR = 0, K_ERR = 1, K_DIV = 2;

  typedef struct {
    int          kind;
    logic [7:0]  a;
    logic [7:0]  d;
    logic [15:0] v;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] baud_div, frame_cnt, err_cnt;
  logic        busy, frame_err;

  int          vectors = 0;
  int          miscompares = 0;
  exp_t        q[$];
  logic [15:0] m_baud = DEF_DIV;
  int          m_good = 0;
  int          m_errs = 0;

  uart_cmd_ctrl_if bus();

  uart_cmd_ctrl #(
    .SYNC_BYTE   (SYNC),
    .DEFAULT_DIV (DEF_DIV),
    .TIMEOUT_CYC (T)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .baud_div  (baud_div),
    .busy      (busy),
    .frame_err (frame_err),
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic void push_ev(input int kind, input logic [7:0] a, input logic [7:0] d,
                                  input logic [15:0] v);
    exp_t e;
    e.kind = kind; e.a = a; e.d = d; e.v = v;
    q.push_back(e);
  endfunction

  // Reference model: outcome of one complete frame, from the frame rules
  function automatic void model_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
    logic [15:0] nv;
    if (c != (a ^ d)) begin
      push_ev(K_ERR, 8'h00, 8'h00, 16'h0000);
      m_errs++;
    end else if (a < 8'h02) begin
      nv = m_baud;
      if (a == 8'h00) nv[7:0]  = d;
      else            nv[15:8] = d;
      if (nv == 16'h0000) begin
        push_ev(K_ERR, 8'h00, 8'h00, 16'h0000);
        m_errs++;
      end else begin
        m_good++;
        if (nv != m_baud) push_ev(K_DIV, 8'h00, 8'h00, nv);
        m_baud = nv;
      end
    end else begin
      push_ev(K_WR, a, d, 16'h0000);
      m_good++;
    end
  endfunction

  function automatic void model_timeout();
    push_ev(K_ERR, 8'h00, 8'h00, 16'h0000);
    m_errs++;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    bus.rx_done_tick = 1'b1;
    bus.rx_data      = b;
    @(negedge clk);
    bus.rx_done_tick = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c,
                            input int gap);
    send_byte(SYNC, gap);
    send_byte(a, gap);
    send_byte(d, gap);
    model_frame(a, d, c);
    send_byte(c, gap);
  endtask

  task automatic check_counters(input string tag);
`ifdef UART_CMD_STATS_EN
    check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(m_good));
    check({tag, "_err_cnt"},   32'(err_cnt),   32'(m_errs));
`else
    check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    check({tag, "_err_cnt"},   32'(err_cnt),   32'd0);
`endif
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_wr_en"},     32'(bus.wr_en),   32'd0);
    check({tag, "_wr_addr"},   32'(bus.wr_addr), 32'd0);
    check({tag, "_wr_data"},   32'(bus.wr_data), 32'd0);
    check({tag, "_baud_div"},  32'(baud_div),    32'(DEF_DIV));
    check({tag, "_busy"},      32'(busy),        32'd0);
    check({tag, "_frame_err"}, 32'(frame_err),   32'd0);
    check({tag, "_frame_cnt"}, 32'(frame_cnt),   32'd0);
    check({tag, "_err_cnt"},   32'(err_cnt),     32'd0);
  endtask

  task automatic expect_event(input int kind, input logic [7:0] a, input logic [7:0] d,
                              input logic [15:0] v);
    exp_t e;
    vectors++;
    if (q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_event: got kind=%0d addr=%h data=%h baud=%h, required no event",
               kind, a, d, v);
      return;
    end
    e = q.pop_front();
    if (e.kind != kind || e.a != a || e.d != d || e.v != v) begin
      miscompares++;
      $display("FAIL event: got kind=%0d addr=%h data=%h baud=%h, required kind=%0d addr=%h data=%h baud=%h",
               kind, a, d, v, e.kind, e.a, e.d, e.v);
    end
  endtask

  // Monitor: every write strobe, error pulse or divisor change is matched to the scoreboard
  initial begin
    logic [15:0] prev_baud;
    prev_baud = DEF_DIV;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_baud = baud_div;
      end else begin
        if (bus.wr_en && frame_err) begin
          vectors++;
          miscompares++;
          $display("FAIL wr_en_and_frame_err: got both 1, required at most one");
        end
        if (bus.wr_en)     expect_event(K_WR, bus.wr_addr, bus.wr_data, 16'h0000);
        if (frame_err)     expect_event(K_ERR, 8'h00, 8'h00, 16'h0000);
        if (baud_div != prev_baud) begin
          expect_event(K_DIV, 8'h00, 8'h00, baud_div);
          prev_baud = baud_div;
        end
      end
    end
  end

  // Watchdog
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int sel, n, g, drain;
    logic [7:0] a, d, c, j;

    bus.rx_done_tick = 1'b0;
    bus.rx_data      = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Plain register write
    send_frame(8'h10, 8'h3C, 8'h2C, 0);
    check("write_busy_low", 32'(busy), 32'd0);
    check("write_wr_en", 32'(bus.wr_en), 32'd1);
    repeat (3) @(negedge clk);

    // Bad checksum
    send_frame(8'h10, 8'h3C, 8'h00, 0);
    repeat (3) @(negedge clk);
    check_counters("after_bad_chk");

    // Divisor writes, then a zero divisor that must be refused
    send_frame(8'h00, 8'h51, 8'h51, 1);
    send_frame(8'h01, 8'h00, 8'h01, 1);
    repeat (3) @(negedge clk);
    check("baud_0051", 32'(baud_div), 32'h0051);
    send_frame(8'h00, 8'h00, 8'h00, 0);
    send_frame(8'h01, 8'h00, 8'h01, 0);
    repeat (3) @(negedge clk);
    check("baud_still_0051", 32'(baud_div), 32'h0051);

    // Silence after ADDR
    send_byte(SYNC, 0);
    send_byte(8'h10, 0);
    check("busy_mid_frame", 32'(busy), 32'd1);
    model_timeout();
    repeat (T + 2) @(negedge clk);
    check("busy_after_timeout", 32'(busy), 32'd0);
    send_frame(8'h20, 8'h01, 8'h21, 0);
    repeat (3) @(negedge clk);

    // Byte lands exactly on the expiry cycle: byte wins at every step
    send_byte(SYNC, 0);
    send_byte(8'h33, T - 2);
    send_byte(8'h44, T - 2);
    model_frame(8'h33, 8'h44, 8'h77);
    send_byte(8'h77, T - 2);
    repeat (3) @(negedge clk);

    // One cycle too late: timeout, then the late byte is ignored in IDLE
    send_byte(SYNC, 0);
    model_timeout();
    send_byte(8'h10, T - 1);
    repeat (3) @(negedge clk);
    check("busy_late_byte", 32'(busy), 32'd0);

    // Junk in IDLE
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    send_byte(8'hA4, 0);
    check("junk_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check_counters("before_random");

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      g   = $urandom_range(0, 4);
      if (sel == 0) begin
        n = $urandom_range(1, 3);
        for (int k = 0; k < n; k++) begin
          j = 8'($urandom_range(0, 255));
          if (j == SYNC) j = 8'h00;
          send_byte(j, g);
        end
      end else if (sel == 1) begin
        n = $urandom_range(0, 2);
        send_byte(SYNC, g);
        for (int k = 0; k < n; k++) send_byte(8'($urandom_range(0, 255)), g);
        model_timeout();
        repeat (T + 3) @(negedge clk);
      end else begin
        case ($urandom_range(0, 3))
          0:       a = 8'h00;
          1:       a = 8'h01;
          default: a = 8'($urandom_range(2, 255));
        endcase
        d = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
        c = a ^ d;
        if ($urandom_range(0, 3) == 0) c = c ^ 8'($urandom_range(1, 255));
        send_frame(a, d, c, g);
      end
      repeat (2) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check("random_baud", 32'(baud_div), 32'(m_baud));
    check_counters("after_random");

    // Reset in the middle of a frame
    send_byte(SYNC, 0);
    send_byte(8'h10, 0);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check_reset_values("mid_reset");
    m_baud = DEF_DIV;
    m_good = 0;
    m_errs = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    send_frame(8'h20, 8'h01, 8'h21, 0);
    repeat (3) @(negedge clk);
    check("post_reset_wr_addr", 32'(bus.wr_addr), 32'h20);
    check_counters("post_reset");

    drain = 0;
    while (q.size() != 0 && drain < 20) begin
      @(negedge clk);
      drain++;
    end
    check("scoreboard_empty", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
